rf_write_scheduler: RTL and testbench
=====================================

# rf_write_scheduler

Sequencer and arbiter for the 8-bit, 16-entry register file's single write port. After reset it zero-fills every register, one per cycle, because the register file's own reset clears only entries 0–4. It then shares the write port between two requesters, A (ALU writeback) and B (load writeback), using round-robin arbitration and valid/ready handshakes. It drives the register file's WriteEn/Waddr/DataIn directly, from registered outputs.

## Interface
- W, 8, data width; must match register-file W
- A, 4, address width; the register file holds 2**A entries
- Clk  in  1  clock
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk
- ValidA  in  1  requester A has a write pending
- AddrA  in  A  requester A destination register
- DataA  in  W  requester A write data
- ReadyA  out  1  grant to A; handshake when ValidA&&ReadyA at posedge
- ValidB, AddrB, DataB  in  1/A/W  requester B, same meaning as A
- ReadyB  out  1  grant to B
- WriteEn  out  1  to register file WriteEn (registered)
- Waddr  out  A  to register file Waddr (registered)
- DataIn  out  W  to register file DataIn (registered)
- InitDone  out  1  high once zero-fill is complete (registered)

## Operation
- States: INIT, RUN. Address counter Cnt is A bits wide. LastGrant is 1 bit (0=A, 1=B).
- Reset (any posedge with Reset=1), regardless of state:
  - State=INIT, Cnt=0, LastGrant=B.
  - WriteEn=0, Waddr=0, DataIn=0, InitDone=0.
  - Any in-flight write is discarded.
- INIT, each posedge with Reset=0:
  - {WriteEn,Waddr,DataIn} <= {1,Cnt,0}.
  - If Cnt==2**A-1: State<=RUN and InitDone<=1. Otherwise Cnt<=Cnt+1.
  - ReadyA=ReadyB=0 throughout INIT. Requester inputs are ignored.
- RUN, combinational grant:
  - Only one requester valid: it gets Ready.
  - Both valid: the one that is not LastGrant gets Ready.
  - Neither valid: ReadyA=ReadyB=0.
  - ReadyA and ReadyB are never both 1.
  - Ready does not depend on the current Valid of the other requester beyond this rule, so Valid→Ready is a combinational path.
- RUN, each posedge:
  - On a handshake with requester X: {WriteEn,Waddr,DataIn} <= {1,AddrX,DataX} and LastGrant<=X.
  - With no handshake: WriteEn<=0. Waddr and DataIn hold their values. LastGrant holds.
- Same-address requests from A and B in the same cycle are not merged. Each is written in its own grant cycle, in grant order, so the later grant wins in the register file.
- Requesters must hold Valid/Addr/Data stable until their handshake. The scheduler does not buffer ungranted requests.
- InitDone stays 1 until the next Reset.

## Timing
- Reset deasserted before posedge P0:
  - Init writes are presented after P0..P(2**A-1), with addresses 0..15 in order.
  - InitDone rises after P15, together with the address-15 write.
  - Register k is zero after posedge P(k+1).
- The first RUN grant is possible in the cycle after P15.
- Write latency: handshake at posedge N → WriteEn/Waddr/DataIn valid during cycle N..N+1 → register updated at posedge N+1. Read ports see the new value after N+1. The scheduler does not forward.
- Throughput is one accepted write per cycle. With both requesters continuously valid, grants strictly alternate A,B,A,B…; the first contested grant after reset goes to A.
- Reset asserted mid-INIT or mid-RUN: the zero-fill restarts from address 0 on the first posedge after deassertion. A handshake in the same cycle as Reset=1 is not performed (ReadyA/B=0 whenever Reset=1).

## Test plan
- Zero-fill: preload RF entries 5–15 with 8'hAA via a testbench backdoor, then apply reset for 2 cycles → WriteEn=1 for exactly 16 cycles, Waddr=0..15, DataIn=0; InitDone=1 after the 16th; all 16 entries read 0.
- Single requester: after InitDone, ValidA=1, AddrA=3, DataA=8'h5C for one cycle → ReadyA=1 the same cycle; WriteEn=1, Waddr=3, DataIn=5C in the next cycle; RF[3]=5C one edge later; ReadyB=0 throughout.
- Contention: ValidA and ValidB held high for 6 cycles (AddrA=1, DataA=8'h11; AddrB=2, DataB=8'h22) → grants alternate A,B,A,B,A,B starting with A; WriteEn=1 in all 6 cycles.
- Same address: A(7,8'h01) and B(7,8'h02) both valid, with LastGrant=B → A is granted first, then B; RF[7]=8'h02 at the end.
- Idle gap: one handshake followed by 3 idle cycles → WriteEn=1 for one cycle, then 0 for 3 cycles; Waddr/DataIn hold.
- Reset mid-operation: Reset=1 for one cycle during init address 9, and again during a RUN contention burst → ReadyA/B=0 and WriteEn=0 while Reset=1; the sweep restarts at address 0; the first post-init contested grant goes to A.

Source files
------------

// File: rtl/rf_write_scheduler.sv
// Zero-fills the register file after reset, then round-robin arbitrates its single write port between A and B.
// Grant is combinational from Valid; write outputs are registered one cycle after the handshake; ungranted requesters are held off via Ready.
module rf_write_scheduler #(
    parameter int W = 8,
    parameter int A = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ValidA,
    input  logic [A-1:0] AddrA,
    input  logic [W-1:0] DataA,
    output logic         ReadyA,
    input  logic         ValidB,
    input  logic [A-1:0] AddrB,
    input  logic [W-1:0] DataB,
    output logic         ReadyB,
    output logic         WriteEn,
    output logic [A-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         InitDone
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t       state_q, state_d;
    logic [A-1:0] cnt_q, cnt_d;
    logic [A-1:0] waddr_q, waddr_d;
    logic [W-1:0] data_q, data_d;
    logic         last_grant_q, last_grant_d;   // 0 = A, 1 = B
    logic         we_q, we_d;
    logic         init_done_q, init_done_d;
    logic         rdy_a, rdy_b;

    // Gated by Reset so no handshake can complete on a resetting edge.
    always_comb begin
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        if (!Reset && state_q == ST_RUN) begin
            rdy_a = ValidA && (!ValidB || last_grant_q);
            rdy_b = ValidB && (!ValidA || !last_grant_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        data_d       = data_q;
        init_done_d  = init_done_q;
        case (state_q)
            ST_INIT: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                data_d  = '0;
                if (&cnt_q) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + A'(1);
                end
            end
            ST_RUN: begin
                if (rdy_a) begin
                    we_d         = 1'b1;
                    waddr_d      = AddrA;
                    data_d       = DataA;
                    last_grant_d = 1'b0;
                end else if (rdy_b) begin
                    we_d         = 1'b1;
                    waddr_d      = AddrB;
                    data_d       = DataB;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            data_q       <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
            init_done_q  <= init_done_d;
        end
    end

    assign ReadyA   = rdy_a;
    assign ReadyB   = rdy_b;
    assign WriteEn  = we_q;
    assign Waddr    = waddr_q;
    assign DataIn   = data_q;
    assign InitDone = init_done_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench: drives the scheduler, models the register file it feeds, and checks against hand-computed values.
module tb_rf_write_scheduler;

    localparam int W = 8;
    localparam int A = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         ValidA, ValidB;
    logic [A-1:0] AddrA, AddrB;
    logic [W-1:0] DataA, DataB;
    logic         ReadyA, ReadyB;
    logic         WriteEn;
    logic [A-1:0] Waddr;
    logic [W-1:0] DataIn;
    logic         InitDone;

    logic [W-1:0] rf [16];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    rf_write_scheduler #(.W(W), .A(A)) dut (
        .Clk(Clk), .Reset(Reset),
        .ValidA(ValidA), .AddrA(AddrA), .DataA(DataA), .ReadyA(ReadyA),
        .ValidB(ValidB), .AddrB(AddrB), .DataB(DataB), .ReadyB(ReadyB),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn), .InitDone(InitDone)
    );

    // Register file: its own reset clears only entries 0..4.
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 5; i++) rf[i] <= '0;
        end else if (WriteEn) begin
            rf[Waddr] <= DataIn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input int addr, input int dat);
        chk({tag, ".we"},   32'(WriteEn), 32'(we));
        chk({tag, ".addr"}, 32'(Waddr),   32'(addr));
        chk({tag, ".data"}, 32'(DataIn),  32'(dat));
    endtask

    task automatic chk_rdy(input string tag, input logic ra, input logic rb);
        #1;
        chk({tag, ".rdyA"}, 32'(ReadyA), 32'(ra));
        chk({tag, ".rdyB"}, 32'(ReadyB), 32'(rb));
    endtask

    // Runs the 16-cycle zero-fill from the first posedge after reset release.
    task automatic sweep(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk_rdy({tag, ".init"}, 1'b0, 1'b0);
            tick();
            chk_wr({tag, ".init"}, 1'b1, k, 0);
            chk({tag, ".initdone"}, 32'(InitDone), 32'(k == 15));
        end
    endtask

    initial begin
        Reset = 1'b1;
        ValidA = 1'b0; ValidB = 1'b0;
        AddrA = '0; AddrB = '0; DataA = '0; DataB = '0;
        for (int i = 5; i < 16; i++) rf[i] = 8'hAA;

        // Reset state and zero-fill, with both requesters asserting during init
        tick();
        tick();
        chk_wr("reset", 1'b0, 0, 0);
        chk("reset.initdone", 32'(InitDone), 32'(0));
        chk_rdy("reset", 1'b0, 1'b0);
        Reset = 1'b0;
        ValidA = 1'b1; ValidB = 1'b1;
        AddrA = 4'd9; DataA = 8'h99;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) begin ValidA = 1'b0; ValidB = 1'b0; end
            chk_rdy("fill", 1'b0, 1'b0);
            tick();
            chk_wr("fill", 1'b1, k, 0);
            chk("fill.initdone", 32'(InitDone), 32'(k == 15));
        end
        chk_rdy("idle_after_fill", 1'b0, 1'b0);
        tick();
        chk("fill.we_off", 32'(WriteEn), 32'(0));
        chk("fill.initdone_hold", 32'(InitDone), 32'(1));
        for (int i = 0; i < 16; i++) chk($sformatf("fill.rf%0d", i), 32'(rf[i]), 32'(0));

        // Contention: strict alternation starting with A
        ValidA = 1'b1; AddrA = 4'd1; DataA = 8'h11;
        ValidB = 1'b1; AddrB = 4'd2; DataB = 8'h22;
        for (int i = 0; i < 6; i++) begin
            chk_rdy($sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
            chk_wr($sformatf("cont%0d", i), 1'b1, ((i % 2) == 0) ? 1 : 2, ((i % 2) == 0) ? 8'h11 : 8'h22);
        end
        ValidA = 1'b0; ValidB = 1'b0;

        // Same address, LastGrant=B: A first, B second, B's data survives
        ValidA = 1'b1; AddrA = 4'd7; DataA = 8'h01;
        ValidB = 1'b1; AddrB = 4'd7; DataB = 8'h02;
        chk_rdy("same0", 1'b1, 1'b0);
        tick();
        ValidA = 1'b0;
        chk_wr("same0", 1'b1, 7, 8'h01);
        chk_rdy("same1", 1'b0, 1'b1);
        tick();
        ValidB = 1'b0;
        chk_wr("same1", 1'b1, 7, 8'h02);
        tick();
        chk("same.rf7", 32'(rf[7]), 32'(8'h02));
        chk("same.we_off", 32'(WriteEn), 32'(0));

        // Single requester A then three idle cycles
        ValidA = 1'b1; AddrA = 4'd3; DataA = 8'h5C;
        chk_rdy("single", 1'b1, 1'b0);
        tick();
        ValidA = 1'b0; AddrA = 4'd0; DataA = 8'h00;
        chk_wr("single", 1'b1, 3, 8'h5C);
        for (int i = 0; i < 3; i++) begin
            chk_rdy($sformatf("idle%0d", i), 1'b0, 1'b0);
            tick();
            chk_wr($sformatf("idle%0d", i), 1'b0, 3, 8'h5C);
        end
        chk("single.rf3", 32'(rf[3]), 32'(8'h5C));

        // Reset during init address 9: sweep restarts from 0
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk_wr("mid_init.pre", 1'b1, 9, 0);
        Reset = 1'b1;
        ValidA = 1'b1; ValidB = 1'b1;
        chk_rdy("mid_init.rst", 1'b0, 1'b0);
        tick();
        chk_wr("mid_init.rst", 1'b0, 0, 0);
        chk("mid_init.initdone", 32'(InitDone), 32'(0));
        Reset = 1'b0;
        ValidA = 1'b0; ValidB = 1'b0;
        sweep("restart");

        // Reset during a RUN contention burst; first contested grant afterwards is A
        ValidA = 1'b1; AddrA = 4'd1; DataA = 8'h11;
        ValidB = 1'b1; AddrB = 4'd2; DataB = 8'h22;
        chk_rdy("burst0", 1'b1, 1'b0);
        tick();
        chk_rdy("burst1", 1'b0, 1'b1);
        tick();
        chk_wr("burst1", 1'b1, 2, 8'h22);
        Reset = 1'b1;
        chk_rdy("burst.rst", 1'b0, 1'b0);
        tick();
        chk_wr("burst.rst", 1'b0, 0, 0);
        chk("burst.initdone", 32'(InitDone), 32'(0));
        Reset = 1'b0;
        sweep("reinit");
        chk_rdy("post_init", 1'b1, 1'b0);
        tick();
        ValidA = 1'b0; ValidB = 1'b0;
        chk_wr("post_init", 1'b1, 1, 8'h11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
